detect_10011: RTL and testbench
===============================

// Module: detect_10011
// PURPOSE
//  - Serial bit-stream pattern detector for the 5-bit sequence 1-0-0-1-1 (first bit received first).
//  - Moore FSM: one input bit is sampled per clk rising edge.
//  - z goes high for one cycle after the edge that completes the pattern. Overlapping matches count.
//  - Sits on a 1-bit serial data path as a frame/marker flag generator.
// PARAMETERS
//  - CNT_W  default 8  width of match counter (used only when DETECT_10011_CNT_EN is defined)
// PORTS
//  - clk      input   1      clock; all state changes on rising edge
//  - rst      input   1      asynchronous, active-low reset
//  - x        input   1      serial data bit; sampled on each clk rising edge
//  - z        output  1      match flag; 1 while FSM is in S5
//  - match_cnt output CNT_W  saturating match count (present only with DETECT_10011_CNT_EN)
// BEHAVIOUR
//  - Interface: reset rst, asynchronous, active-low; clock clk.
//  - State register is named `state`, 3 bits. Verification probes it hierarchically.
//    S0=000 idle; S1=001 "1"; S2=010 "10"; S3=011 "100"; S4=100 "1001"; S5=101 "10011".
//  - Reset (rst=0): state=3'b000 immediately, with no clk edge needed. z=0. match_cnt=0.
//    Held for as long as rst=0.
//  - Reset mid-pattern discards all partial history. After release, a match needs 5 fresh bits.
//  - Transitions on clk rising edge (x=0 / x=1):
//    S0: S0 / S1
//    S1: S2 / S1
//    S2: S3 / S1
//    S3: S0 / S4
//    S4: S2 / S5
//    S5: S2 / S1   (overlap: a trailing "1" or "10" is reused as a prefix)
//  - z = (state==S5). z is purely registered-state decoded, with no combinational path from x.
//  - Latency: the edge that samples the final '1' moves the FSM to S5. z is valid right after that edge.
//  - z stays high for exactly one cycle per match, because S5 always exits on the next edge.
//  - Illegal codes 110/111 go to S0 on the next edge, with z=0 while in them.
//  - x=X/Z: treated as the edge's sample value. No special handling; the bench drives known values.
// CONFIGURATION
//  - Macro DETECT_10011_CNT_EN:
//    - Defined: adds output match_cnt[CNT_W-1:0]. It increments on each edge that enters S5.
//      It saturates at all-ones and clears on reset.
//    - Undefined: port and counter are absent. z/state behaviour is identical either way.
// TESTING
//  - Reset: pulse rst=0 for 2ns mid-cycle -> state==000 and z==0 within 1ns, before the next clk edge.
//  - Single match: after reset, x = 1,0,0,1,1 on 5 edges -> z=0 after edges 1-4, z=1 after edge 5.
//    Then x=0 -> z=0 and state=010.
//  - Overlap: stream 1001100110011 -> z=1 after the 5th and 9th bits and again after the 13th bit.
//    z=0 after every other edge.
//  - Near-misses: 10010011 -> single z pulse, after the final bit.
//    1000 then 10011 -> one pulse, after the final bit.
//  - Random: 1000 random bits with a 5-bit history model.
//    z must equal (history==10011) 1ns after every edge. Zero mismatches.
//  - Random reset: 100 cycles with 50% async reset pulses.
//    After each pulse, state==000. The history model is cleared, so no false z until 5 new bits arrive.
//    With DETECT_10011_CNT_EN, match_cnt equals the model's match count and saturates at 2^CNT_W-1.

Source files
------------

// File: rtl/detect_10011.sv
// detect_10011: Moore detector for serial pattern 10011 (overlapping matches).
// Define DETECT_10011_CNT_EN to add the saturating match_cnt output.
module detect_10011 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
`ifdef DETECT_10011_CNT_EN
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             z
);
  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100,
    S5 = 3'b101
  } state_t;
  state_t state, state_nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S0;
    else      state <= state_nxt;
  // Undefined codes fall through to S0
  always_comb begin
    state_nxt = S0;
    case (state)
      S0: state_nxt = x ? S1 : S0;
      S1: state_nxt = x ? S1 : S2;
      S2: state_nxt = x ? S1 : S3;
      S3: state_nxt = x ? S4 : S0;
      S4: state_nxt = x ? S5 : S2;
      S5: state_nxt = x ? S1 : S2;
      default: state_nxt = S0;
    endcase
  end
  assign z = (state == S5);
`ifdef DETECT_10011_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) match_cnt <= '0;
    else if (state_nxt == S5 && !(&match_cnt)) match_cnt <= match_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_detect_10011.sv
// tb_detect_10011: randomized check of detect_10011 against a bit-history model.
module tb_detect_10011;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x = 1'b0;
  logic z;
`ifdef DETECT_10011_CNT_EN
  logic [CW-1:0] match_cnt;
`endif
  int checks = 0;
  int errors = 0;
  logic [4:0] hist;
  int nbits;
  int mcnt;
  always #5 clk = ~clk;
  detect_10011 #(.CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .x(x),
`ifdef DETECT_10011_CNT_EN
    .match_cnt(match_cnt),
`endif
    .z(z)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic clear_model();
    hist = '0;
    nbits = 0;
    mcnt = 0;
  endtask
  task automatic step(input logic b);
    logic hit;
    @(negedge clk);
    x = b;
    @(posedge clk);
    hist = {hist[3:0], b};
    nbits++;
    hit = (nbits >= 5) && (hist == 5'b10011);
    if (hit && mcnt < (1 << CW) - 1) mcnt++;
    #1;
    check("z", {31'b0, z}, {31'b0, hit});
`ifdef DETECT_10011_CNT_EN
    check("match_cnt", {{(32-CW){1'b0}}, match_cnt}, mcnt);
`endif
  endtask
  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(v[i]);
  endtask
  // Pulse lands between edges so only the asynchronous path can clear state
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_state", {29'b0, dut.state}, 32'd0);
    check("rst_z", {31'b0, z}, 32'd0);
`ifdef DETECT_10011_CNT_EN
    check("rst_cnt", {{(32-CW){1'b0}}, match_cnt}, 32'd0);
`endif
    #1 rst = 1'b1;
    clear_model();
  endtask
  initial begin
    clear_model();
    #1;
    check("init_state", {29'b0, dut.state}, 32'd0);
    check("init_z", {31'b0, z}, 32'd0);
    #2 rst = 1'b1;
    send(32'b10011, 5);
    check("single_z", {31'b0, z}, 32'd1);
    step(1'b0);
    check("single_exit_state", {29'b0, dut.state}, 32'd2);
    pulse_reset();
    send(32'b1001100110011, 13);
    pulse_reset();
    send(32'b10010011, 8);
    pulse_reset();
    send(32'b1000, 4);
    send(32'b10011, 5);
    pulse_reset();
    send(32'b1001, 4);
    pulse_reset();
    send(32'b1, 1);
    for (int i = 0; i < 1000; i++) step(1'($urandom_range(0, 1)));
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 1) pulse_reset();
      step(1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
